// File: rtl/mbus_interleaved_mem.sv
// MBUS core-memory model: NCHAN phase channels share one word array and one read-data bus.
// Read, write and RPW quad-word cycles with arbitrary request masks and NXM flagging.
module mbus_interleaved_mem #(
    parameter int NCHAN    = 2,
    parameter int ADRW     = 22,
    parameter int DW       = 36,
    parameter int MEMWORDS = 512*1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCHAN-1:0] start,
    input  logic             rd_rq,
    input  logic             wr_rq,
    input  logic [3:0]       rq,
    input  logic [ADRW-1:0]  adr,
    input  logic [DW-1:0]    d_out,
    input  logic [NCHAN-1:0] valid_out,
    output logic [NCHAN-1:0] ackn,
    output logic [NCHAN-1:0] valid_in,
    output logic [DW-1:0]    d_in,
    output logic             par_in,
    output logic [NCHAN-1:0] nxm
);
    localparam int AW = $clog2(MEMWORDS);
    localparam logic [ADRW:0] LIMIT = (ADRW+1)'(MEMWORDS);

    typedef enum logic [2:0] {IDLE, ACKW, RDATA, WWAIT, RPWW} state_t;

    state_t           state_q [NCHAN];
    state_t           state_d [NCHAN];
    logic [3:0]       rem_q   [NCHAN];
    logic [3:0]       rem_d   [NCHAN];
    logic [3:0]       rem_nx  [NCHAN];
    logic [ADRW-1:0]  adr_q   [NCHAN];
    logic [ADRW-1:0]  wadr    [NCHAN];
    logic [NCHAN-1:0] start_q, rd_q, wr_q, nxm_q, nxm_d;
    logic [NCHAN-1:0] accept, we, wnxm, grant;
    logic [DW-1:0]    d_in_q;
    logic [DW-1:0]    mem [MEMWORDS];

    function automatic logic [1:0] first_word(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // rem_q holds the words still to do; the lowest set bit is the current word
    always_comb begin : word_addr
        for (int unsigned c = 0; c < NCHAN; c++) begin
            wadr[c]   = {adr_q[c][ADRW-1:2], adr_q[c][1:0] + first_word(rem_q[c])};
            wnxm[c]   = {1'b0, wadr[c]} >= LIMIT;
            rem_nx[c] = rem_q[c] & ~(4'b0001 << first_word(rem_q[c]));
        end
    end

    always_comb begin : bus_arb
        grant = '0;
        d_in  = d_in_q;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (state_q[c] == RDATA && grant == '0) begin
                grant[c] = 1'b1;
                d_in     = wnxm[c] ? '0 : mem[wadr[c][AW-1:0]];
            end
        end
    end

    always_comb begin : outs
        for (int unsigned c = 0; c < NCHAN; c++) begin
            ackn[c] = (state_q[c] == ACKW);
        end
        valid_in = grant;
        par_in   = ~^d_in;
        nxm      = nxm_q;
    end

    always_comb begin : next_state
        accept = '0;
        we     = '0;
        nxm_d  = nxm_q;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            state_d[c] = state_q[c];
            rem_d[c]   = rem_q[c];
            case (state_q[c])
                IDLE: begin
                    if (start[c] && !start_q[c]) begin
                        accept[c] = 1'b1;
                        nxm_d[c]  = 1'b0;
                        rem_d[c]  = rq;
                        if (rq != '0 && (rd_rq || wr_rq)) state_d[c] = ACKW;
                    end
                end
                ACKW: begin
                    if (wnxm[c]) nxm_d[c] = 1'b1;
                    if (rd_q[c]) begin
                        state_d[c] = RDATA;
                    end else if (valid_out[c]) begin
                        we[c]      = 1'b1;
                        rem_d[c]   = rem_nx[c];
                        state_d[c] = (rem_nx[c] == '0) ? IDLE : ACKW;
                    end else begin
                        state_d[c] = WWAIT;
                    end
                end
                RDATA: begin
                    if (grant[c]) begin
                        if (wr_q[c]) begin
                            state_d[c] = RPWW;
                        end else begin
                            rem_d[c]   = rem_nx[c];
                            state_d[c] = (rem_nx[c] == '0) ? IDLE : ACKW;
                        end
                    end
                end
                WWAIT, RPWW: begin
                    if (valid_out[c]) begin
                        we[c]      = 1'b1;
                        rem_d[c]   = rem_nx[c];
                        state_d[c] = (rem_nx[c] == '0) ? IDLE : ACKW;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                state_q[c] <= IDLE;
                rem_q[c]   <= '0;
            end
            start_q <= '0;
            nxm_q   <= '0;
            d_in_q  <= '0;
        end else begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                state_q[c] <= state_d[c];
                rem_q[c]   <= rem_d[c];
            end
            start_q <= start;
            nxm_q   <= nxm_d;
            d_in_q  <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (accept[c]) begin
                adr_q[c] <= adr;
                rd_q[c]  <= rd_rq;
                wr_q[c]  <= wr_rq;
            end
        end
    end

    // Highest index first so that the lowest channel's store lands last and wins
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (!reset && we[NCHAN-1-i] && !wnxm[NCHAN-1-i]) begin
                mem[wadr[NCHAN-1-i][AW-1:0]] <= d_out;
            end
        end
    end
endmodule

// File: tb/tb_mbus_interleaved_mem.sv
// Scoreboard bench for mbus_interleaved_mem: directed cases plus randomized cycles
// checked against an address-level memory model.
module tb_mbus_interleaved_mem;
    localparam int NCHAN    = 2;
    localparam int ADRW     = 22;
    localparam int DW       = 36;
    localparam int MEMWORDS = 512*1024;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCHAN-1:0] start;
    logic             rd_rq, wr_rq;
    logic [3:0]       rq;
    logic [ADRW-1:0]  adr;
    logic [DW-1:0]    d_out;
    logic [NCHAN-1:0] valid_out;
    logic [NCHAN-1:0] ackn, valid_in, nxm;
    logic [DW-1:0]    d_in;
    logic             par_in;

    mbus_interleaved_mem #(.NCHAN(NCHAN), .ADRW(ADRW), .DW(DW), .MEMWORDS(MEMWORDS)) dut (
        .clk(clk), .reset(reset), .start(start), .rd_rq(rd_rq), .wr_rq(wr_rq), .rq(rq),
        .adr(adr), .d_out(d_out), .valid_out(valid_out), .ackn(ackn), .valid_in(valid_in),
        .d_in(d_in), .par_in(par_in), .nxm(nxm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt [NCHAN] = '{default: 0};
    int vin_cnt [NCHAN] = '{default: 0};
    logic [DW-1:0] exp0 [$];
    logic [DW-1:0] exp1 [$];
    logic [DW-1:0] ref_mem [int unsigned];
    logic [DW-1:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADRW-1:0] word_addr(input logic [ADRW-1:0] a, input int k);
        int base;
        base = int'(a);
        return ADRW'((base & ~3) | ((base + k) % 4));
    endfunction

    function automatic bit is_nxm(input logic [ADRW-1:0] a);
        return int'(a) >= MEMWORDS;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [ADRW-1:0] a);
        if (is_nxm(a) || !ref_mem.exists(int'(a))) return '0;
        return ref_mem[int'(a)];
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic push_exp(input int ch, input logic [DW-1:0] v);
        if (ch == 0) exp0.push_back(v);
        else         exp1.push_back(v);
    endtask

    // Monitor: every valid_in pops the next expected word for that channel
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                if (ackn[c]) ack_cnt[c]++;
                if (valid_in[c]) begin
                    vin_cnt[c]++;
                    if ((c == 0 && exp0.size() == 0) || (c == 1 && exp1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected valid_in ch%0d: got d_in %0h expected none", c, d_in);
                    end else begin
                        mon_e = (c == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk($sformatf("rdata ch%0d", c), 64'(d_in), 64'(mon_e));
                        chk("parity odd", 64'(^{d_in, par_in}), 64'(1));
                    end
                end
            end
        end
    end

    task automatic wait_sig(input int ch, input bit on_vin, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if ((on_vin ? valid_in[ch] : ackn[ch]) == 1'b1) ok = 1'b1;
            else step();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout ch%0d %s: got none expected pulse", ch, on_vin ? "valid_in" : "ackn");
        end
    endtask

    // One complete cycle on one channel; dly<0 picks a random valid_out delay
    task automatic xact(input int ch, input bit rd, input bit wr, input logic [3:0] m,
                        input logic [ADRW-1:0] a, input int dly, input bit hold,
                        input logic [4*DW-1:0] wd, input bit fixed);
        int a0, v0, nw, d;
        bit any_nx, ok;
        logic [ADRW-1:0] wa;
        logic [DW-1:0] data;
        a0 = ack_cnt[ch];
        v0 = vin_cnt[ch];
        any_nx = 1'b0;
        nw = (m != 4'b0 && (rd || wr)) ? $countones(m) : 0;
        if (nw > 0 && rd)
            for (int k = 0; k < 4; k++)
                if (m[k]) push_exp(ch, model_rd(word_addr(a, k)));
        rd_rq = rd; wr_rq = wr; rq = m; adr = a; start[ch] = 1'b1;
        step();
        if (!hold) start[ch] = 1'b0;
        rq = 4'($urandom); adr = ADRW'($urandom); rd_rq = 1'($urandom); wr_rq = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            if (nw > 0 && m[k]) begin
                wa = word_addr(a, k);
                any_nx |= is_nxm(wa);
                wait_sig(ch, 1'b0, ok);
                if (!ok) return;
                if (rd && !wr) begin
                    step();
                end else begin
                    if (rd) begin
                        step();
                        wait_sig(ch, 1'b1, ok);
                        if (!ok) return;
                        step();
                    end
                    d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                    data = fixed ? wd[k*DW +: DW] : rnd_word();
                    repeat (d) step();
                    valid_out[ch] = 1'b1;
                    d_out = data;
                    step();
                    valid_out[ch] = 1'b0;
                    d_out = rnd_word();
                    if (!is_nxm(wa)) ref_mem[int'(wa)] = data;
                end
            end
        end
        repeat (2) step();
        start[ch] = 1'b0;
        chk($sformatf("ackn count ch%0d", ch), 64'(ack_cnt[ch] - a0), 64'(nw));
        chk($sformatf("valid_in count ch%0d", ch), 64'(vin_cnt[ch] - v0), 64'(rd ? nw : 0));
        chk($sformatf("nxm ch%0d", ch), 64'(nxm[ch]), 64'(any_nx));
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int a0, r;
        reset = 1'b1; start = '0; rd_rq = 1'b0; wr_rq = 1'b0; rq = '0; adr = '0;
        d_out = '0; valid_out = '0;
        repeat (3) step();
        chk("reset ackn", 64'(ackn), 64'(0));
        chk("reset valid_in", 64'(valid_in), 64'(0));
        chk("reset nxm", 64'(nxm), 64'(0));
        chk("reset d_in", 64'(d_in), 64'(0));
        chk("reset par_in", 64'(par_in), 64'(1));
        reset = 1'b0;
        step();

        // Quad read timing: ackn every other cycle, valid_in one cycle after each
        xact(0, 1'b0, 1'b1, 4'b1111, 22'o1000, 0, 1'b0,
             {36'o1003, 36'o1002, 36'o1001, 36'o1000}, 1'b1);
        for (int k = 0; k < 4; k++) push_exp(0, model_rd(word_addr(22'o1000, k)));
        rd_rq = 1'b1; wr_rq = 1'b0; rq = 4'b1111; adr = 22'o1000; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("read T+%0d ackn", 2*k+1), 64'(ackn), 64'(1));
            step();
            chk($sformatf("read T+%0d valid_in", 2*k+2), 64'(valid_in), 64'(1));
            chk($sformatf("read T+%0d ackn low", 2*k+2), 64'(ackn), 64'(0));
            step();
        end
        chk("read done idle", 64'(ackn), 64'(0));

        // Discontiguous write mask with wrap inside the quad-word
        xact(0, 1'b0, 1'b1, 4'b1111, 22'o2000, -1, 1'b0,
             {36'o44, 36'o33, 36'o22, 36'o11}, 1'b1);
        xact(1, 1'b0, 1'b1, 4'b0101, 22'o2002, 2, 1'b0,
             {36'o0, 36'o555, 36'o0, 36'o777}, 1'b1);
        xact(0, 1'b1, 1'b0, 4'b1111, 22'o2000, 0, 1'b0, '0, 1'b0);

        // RPW: read old value, then write new one
        xact(0, 1'b0, 1'b1, 4'b0001, 22'd5, 0, 1'b0, {108'd0, 36'o123}, 1'b1);
        xact(0, 1'b1, 1'b1, 4'b0001, 22'd5, 1, 1'b0, {108'd0, 36'o456}, 1'b1);
        xact(1, 1'b1, 1'b0, 4'b0001, 22'd5, 0, 1'b0, '0, 1'b0);

        // Same-cycle starts: both ack together, bus goes to ch0 first
        push_exp(0, model_rd(22'o1000));
        push_exp(1, model_rd(22'o1000));
        rd_rq = 1'b1; wr_rq = 1'b0; rq = 4'b0001; adr = 22'o1000; start = 2'b11;
        step();
        start = 2'b00;
        chk("dual ackn", 64'(ackn), 64'(2'b11));
        step();
        chk("dual valid_in ch0", 64'(valid_in), 64'(2'b01));
        step();
        chk("dual valid_in ch1", 64'(valid_in), 64'(2'b10));
        repeat (2) step();

        // NXM read and write; flag is sticky until the next accepted start
        xact(0, 1'b1, 1'b0, 4'b0011, 22'(MEMWORDS), 0, 1'b0, '0, 1'b0);
        repeat (3) step();
        chk("nxm sticky", 64'(nxm[0]), 64'(1));
        xact(1, 1'b0, 1'b1, 4'b0001, 22'(MEMWORDS + 2), -1, 1'b0, '0, 1'b0);
        xact(0, 1'b1, 1'b0, 4'b0001, 22'o1001, 0, 1'b0, '0, 1'b0);

        // Start held high through the whole cycle must not retrigger
        xact(1, 1'b1, 1'b0, 4'b1010, 22'o1000, 0, 1'b1, '0, 1'b0);

        // Reset during WWAIT aborts the write
        a0 = ack_cnt[1];
        rd_rq = 1'b0; wr_rq = 1'b1; rq = 4'b0001; adr = 22'o2003; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        wait_sig(1, 1'b0, ok);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort ackn", 64'(ackn), 64'(0));
        chk("abort valid_in", 64'(valid_in), 64'(0));
        chk("abort nxm", 64'(nxm), 64'(0));
        chk("abort d_in", 64'(d_in), 64'(0));
        chk("abort par_in", 64'(par_in), 64'(1));
        valid_out[1] = 1'b1; d_out = 36'o7777;
        repeat (2) step();
        valid_out[1] = 1'b0;
        step();
        chk("abort ackn total", 64'(ack_cnt[1] - a0), 64'(1));
        xact(1, 1'b1, 1'b0, 4'b0001, 22'o2003, 0, 1'b0, '0, 1'b0);

        // Randomized cycles over a preloaded window plus occasional NXM
        for (int i = 0; i < 4; i++)
            xact(i % 2, 1'b0, 1'b1, 4'b1111, 22'(12'o3000 + 4*i), -1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 7));
            xact(int'($urandom_range(0, 1)), r < 3 || (r == 5 || r == 6), (r == 3 || r == 4 || r == 5 || r == 6),
                 4'($urandom),
                 ($urandom_range(0, 9) == 0) ? 22'(MEMWORDS + int'($urandom_range(0, 7)))
                                             : 22'(12'o3000 + int'($urandom_range(0, 15))),
                 -1, ($urandom_range(0, 3) == 0), '0, 1'b0);
        end

        repeat (3) step();
        chk("expected reads drained", 64'(exp0.size() + exp1.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
